// File: rtl/activation_writeback_if.sv
// Bundles the command, accumulator, unified-buffer and status signals of activation_writeback.
// The "slave" modport is the writeback block; "master" is the controller/memory side.
interface activation_writeback_if #(
  parameter int MUL_SIZE  = 16,
  parameter int RES_WIDTH = 31,
  parameter int ACT_WIDTH = 7,
  parameter int ACC_AW    = 7,
  parameter int UB_AW     = 12
);
  logic                                  start_i;
  logic [8:0]                            rows_i;
  logic [ACC_AW-1:0]                     acc_start_addr_i;
  logic [UB_AW-1:0]                      ub_start_addr_i;
  logic [4:0]                            shift_i;
  logic                                  relu_en_i;
  logic                                  hold_i;
  logic                                  accum_rd_en_o;
  logic [ACC_AW-1:0]                     accum_addr_rd_o;
  logic [MUL_SIZE-1:0][RES_WIDTH:0]      accum_data_i;
  logic                                  ub_write_o;
  logic [UB_AW-1:0]                      ub_addr_wr_o;
  logic [MUL_SIZE-1:0][ACT_WIDTH:0]      ub_data_o;
  logic                                  busy_o;
  logic                                  done_o;

  modport slave (
    input  start_i, rows_i, acc_start_addr_i, ub_start_addr_i, shift_i, relu_en_i, hold_i,
    input  accum_data_i,
    output accum_rd_en_o, accum_addr_rd_o,
    output ub_write_o, ub_addr_wr_o, ub_data_o,
    output busy_o, done_o
  );

  modport master (
    output start_i, rows_i, acc_start_addr_i, ub_start_addr_i, shift_i, relu_en_i, hold_i,
    output accum_data_i,
    input  accum_rd_en_o, accum_addr_rd_o,
    input  ub_write_o, ub_addr_wr_o, ub_data_o,
    input  busy_o, done_o
  );
endinterface

// File: rtl/activation_writeback.sv
// Drains accumulator rows through ReLU / rounding shift / saturation into the unified buffer.
// Optional feature macro: ACT_WB_RELU_EN (ReLU stage present and controlled by relu_en_i).
module activation_writeback #(
  parameter int MUL_SIZE  = 16,
  parameter int RES_WIDTH = 31,
  parameter int ACT_WIDTH = 7,
  parameter int ACC_AW    = 7,
  parameter int UB_AW     = 12
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  activation_writeback_if.slave  bus
);

  localparam int EXT = RES_WIDTH + 2;
  localparam logic signed [EXT-1:0] SAT_MAX = (EXT'(1) << ACT_WIDTH) - EXT'(1);
  localparam logic signed [EXT-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                            r_state;
  state_t                            w_nextState;
  logic [8:0]                        r_rowsLeft;
  logic [ACC_AW-1:0]                 r_accAddr;
  logic [UB_AW-1:0]                  r_ubNext;
  logic [UB_AW-1:0]                  r_ubAddr;
  logic [4:0]                        r_shift;
  logic                              r_vldRd;
  logic                              r_vldA;
  logic                              r_write;
  logic [MUL_SIZE-1:0][RES_WIDTH:0]  r_dataA;
  logic [MUL_SIZE-1:0][ACT_WIDTH:0]  r_ubData;
  logic [MUL_SIZE-1:0][ACT_WIDTH:0]  w_sat;
  logic                              w_startOk;
  logic                              w_issue;
  logic                              w_done;
  logic                              w_busy;

`ifdef ACT_WB_RELU_EN
  logic                              r_relu;
`else
  logic                              w_unusedRelu;
  assign w_unusedRelu = bus.relu_en_i;
`endif

  assign w_startOk = (r_state == IDLE) && bus.start_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:  if (bus.start_i) w_nextState = (bus.rows_i != 9'd0) ? READ : DONE;
      READ:  if (!bus.hold_i && (r_rowsLeft == 9'd1)) w_nextState = DRAIN;
      // Stage C needs no wait: its last write lands in the same cycle DRAIN exits.
      DRAIN: if (!r_vldRd && !r_vldA) w_nextState = DONE;
      DONE:  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_issue = (r_state == READ) && !bus.hold_i;
    w_done  = (r_state == DONE);
    w_busy  = (r_state != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rowsLeft <= '0;
      r_accAddr  <= '0;
      r_ubNext   <= '0;
      r_shift    <= '0;
`ifdef ACT_WB_RELU_EN
      r_relu     <= 1'b0;
`endif
    end else if (w_startOk) begin
      r_rowsLeft <= bus.rows_i;
      r_accAddr  <= bus.acc_start_addr_i;
      r_ubNext   <= bus.ub_start_addr_i;
      r_shift    <= bus.shift_i;
`ifdef ACT_WB_RELU_EN
      r_relu     <= bus.relu_en_i;
`endif
    end else begin
      if (w_issue) begin
        r_rowsLeft <= r_rowsLeft - 9'd1;
        r_accAddr  <= r_accAddr + 1'b1;
      end
      if (r_vldA) r_ubNext <= r_ubNext + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_vldRd  <= 1'b0;
      r_vldA   <= 1'b0;
      r_write  <= 1'b0;
      r_dataA  <= '0;
      r_ubData <= '0;
      r_ubAddr <= '0;
    end else begin
      r_vldRd <= w_issue;
      r_vldA  <= r_vldRd;
      r_write <= r_vldA;
      if (r_vldRd) r_dataA <= bus.accum_data_i;
      if (r_vldA) begin
        r_ubData <= w_sat;
        r_ubAddr <= r_ubNext;
      end
    end
  end

  // One extra bit of headroom keeps the rounding add from overflowing.
  always_comb begin
    logic signed [EXT-1:0] w_ext;
    logic signed [EXT-1:0] w_round;
    logic signed [EXT-1:0] w_sum;
    logic signed [EXT-1:0] w_shifted;
    w_sat = '0;
    for (int l = 0; l < MUL_SIZE; l++) begin
      w_ext = {r_dataA[l][RES_WIDTH], r_dataA[l]};
`ifdef ACT_WB_RELU_EN
      if (r_relu && w_ext[EXT-1]) w_ext = '0;
`endif
      w_round   = (r_shift == 5'd0) ? '0 : (EXT'(1) << (r_shift - 5'd1));
      w_sum     = w_ext + w_round;
      w_shifted = (r_shift == 5'd0) ? w_ext : (w_sum >>> r_shift);
      if (w_shifted > SAT_MAX)      w_sat[l] = SAT_MAX[ACT_WIDTH:0];
      else if (w_shifted < SAT_MIN) w_sat[l] = SAT_MIN[ACT_WIDTH:0];
      else                          w_sat[l] = w_shifted[ACT_WIDTH:0];
    end
  end

  assign bus.accum_rd_en_o   = w_issue;
  assign bus.accum_addr_rd_o = r_accAddr;
  assign bus.ub_write_o      = r_write;
  assign bus.ub_addr_wr_o    = r_ubAddr;
  assign bus.ub_data_o       = r_ubData;
  assign bus.busy_o          = w_busy;
  assign bus.done_o          = w_done;

endmodule
